// File: rtl/fifo_ctrl_fwft.sv
// First-word-fall-through FIFO controller for an external 1-cycle registered-read dual-port RAM.
// Head entry lives in the RAM read register; optional almost flags under FIFO_CTRL_STATUS_EN.
module fifo_ctrl_fwft #(
    parameter int ADDR_WIDTH          = 4,
    parameter int DATA_WIDTH          = 32
`ifdef FIFO_CTRL_STATUS_EN
    ,
    parameter int ALMOST_FULL_THRESH  = 12,
    parameter int ALMOST_EMPTY_THRESH = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef FIFO_CTRL_STATUS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] wptr, rptr, ram_cnt;
    logic [ADDR_WIDTH:0] wptr_nxt, rptr_nxt;
    logic                head_valid, head_nxt, pop;

    // Extra pointer MSB tells a full RAM apart from an empty one.
    assign ram_cnt   = wptr - rptr;
    assign count     = ram_cnt + {{ADDR_WIDTH{1'b0}}, head_valid};

    assign wr_ready  = (ram_cnt != FULL_CNT);
    assign ram_we    = wr_valid && wr_ready;
    assign ram_din   = wr_data;
    assign ram_waddr = wptr[ADDR_WIDTH-1:0];

    assign rd_valid  = head_valid;
    assign rd_data   = ram_dout;
    assign pop       = head_valid && rd_ready;

    // Refill the read register whenever it is empty or being drained this cycle;
    // only committed entries are read, so no write-to-read bypass is needed.
    assign ram_re    = (ram_cnt != '0) && (!head_valid || pop);
    assign ram_raddr = rptr[ADDR_WIDTH-1:0];

    assign wptr_nxt  = wptr + {{ADDR_WIDTH{1'b0}}, ram_we};
    assign rptr_nxt  = rptr + {{ADDR_WIDTH{1'b0}}, ram_re};
    assign head_nxt  = ram_re || (head_valid && !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            head_valid <= 1'b0;
        end else begin
            wptr       <= wptr_nxt;
            rptr       <= rptr_nxt;
            head_valid <= head_nxt;
        end
    end

`ifdef FIFO_CTRL_STATUS_EN
    logic [ADDR_WIDTH:0] count_nxt;

    // Flags are registered from the next-state count so they line up with count.
    assign count_nxt = (wptr_nxt - rptr_nxt) + {{ADDR_WIDTH{1'b0}}, head_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (int'(count_nxt) >= ALMOST_FULL_THRESH);
            almost_empty <= (int'(count_nxt) <= ALMOST_EMPTY_THRESH);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl_fwft.sv
// Randomised scoreboard bench for fifo_ctrl_fwft with a behavioural RAM and queue model.
module tb_fifo_ctrl_fwft;
    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic          ram_we, ram_re;
    logic [DW-1:0] ram_din, ram_dout;
`ifdef FIFO_CTRL_STATUS_EN
    logic          almost_full, almost_empty;
`endif

    always #5 clk = ~clk;

    fifo_ctrl_fwft #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
`ifdef FIFO_CTRL_STATUS_EN
        ,
        .ALMOST_FULL_THRESH(4),
        .ALMOST_EMPTY_THRESH(1)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count),
        .ram_waddr(ram_waddr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_dout(ram_dout)
`ifdef FIFO_CTRL_STATUS_EN
        ,
        .almost_full(almost_full), .almost_empty(almost_empty)
`endif
    );

    // Simple dual-port RAM, one-cycle registered read with read enable.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: entries in order, each tagged with the edge that stored it.
    logic [DW-1:0] exp_q[$];
    int            ts_q[$];
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // An entry becomes the visible head one edge after it was stored, once it is oldest.
    function automatic bit head_visible();
        return (exp_q.size() > 0) && (cyc >= ts_q[0] + 1);
    endfunction

    // Monitor: compares status against the model, then scores pops.
    initial begin
        int  n;
        bit  vis;
        bit  wr_rdy_exp;
        forever begin
            @(negedge clk);
            n          = exp_q.size();
            vis        = head_visible();
            wr_rdy_exp = (n - int'(vis)) < 4;
            check("count", 32'(count), n);
            check("rd_valid", 32'(rd_valid), 32'(vis));
            check("wr_ready", 32'(wr_ready), 32'(wr_rdy_exp));
            check("ram_we", 32'(ram_we), 32'(wr_valid && wr_rdy_exp));
`ifdef FIFO_CTRL_STATUS_EN
            check("almost_full", 32'(almost_full), 32'(n >= 4));
            check("almost_empty", 32'(almost_empty), 32'(n <= 1));
`endif
            if (ram_we && ram_re)
                check("ram_addr_collision", 32'(ram_waddr != ram_raddr), 32'd1);
            if (rd_valid && rd_ready) begin
                if (n == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty: DUT popped with model holding %0d entries", n);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                    void'(ts_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr);
        @(posedge clk);
        #1;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #6;
        if (wr_valid && wr_ready) begin
            exp_q.push_back(wd);
            ts_q.push_back(cyc + 1);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            step(1'b0, '0, 1'b1);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(count), 0);
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_wr_ready", 32'(wr_ready), 1);
        check("reset_ram_re", 32'(ram_re), 0);
        rst_n = 1'b1;

        // Single entry through an empty FIFO.
        step(1'b1, 8'hA1, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        // Fill to capacity, one refused push, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'h15, 1'b0);
        check("full_wr_ready", 32'(wr_ready), 0);
        check("full_count", 32'(count), 5);
        drain();

        // Streaming push and pop every cycle.
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1);
        drain();

        // Full, then concurrent push/pop across pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h80 + i), 1'b1);
        drain();

        // Random traffic, write-heavy then read-heavy.
        for (int i = 0; i < 250; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 250; i++)
            step(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        drain();

        // Asynchronous reset with entries held.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        check("pre_reset_count", 32'(count), 3);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_rd_valid", 32'(rd_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_wr_ready", 32'(wr_ready), 1);
        check("arst_ram_we", 32'(ram_we), 0);
        check("arst_ram_re", 32'(ram_re), 0);
        exp_q.delete();
        ts_q.delete();
        repeat (2) step(1'b0, '0, 1'b0);
        #1 rst_n = 1'b1;
        step(1'b1, 8'h55, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
